// File: rtl/alu_control_seq.sv
// rtl/alu_control_seq.sv - registered ALU-control decoder with mult/div busy sequencer
module alu_control_seq #(
  parameter int CTRL_W  = 4,
  parameter int MUL_LAT = 4,
  parameter int DIV_LAT = 32,
  parameter int CNT_W   = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              valid_i,
  input  logic [1:0]        alu_op,
  input  logic [5:0]        opcode,
  input  logic [5:0]        funct,
  output logic              stall,
  output logic [CTRL_W-1:0] alu_control,
  output logic              ctrl_valid,
  output logic              md_start,
  output logic [1:0]        md_op,
  output logic              md_done,
  output logic              illegal
);

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             accept;
  logic [3:0]       dec_ctrl;
  logic             dec_ill;
  logic             dec_md;

  // Stall depends on state only, so valid_i never loops back into it.
  assign stall  = (state == BUSY);
  assign accept = valid_i && (state == IDLE);

  always_comb begin
    dec_ctrl = ALU_ADD;
    dec_ill  = 1'b0;
    dec_md   = 1'b0;
    case (alu_op)
      2'b00: dec_ctrl = ALU_ADD;
      2'b01: begin
        case (opcode)
          6'b001101: dec_ctrl = ALU_OR;
          6'b001100: dec_ctrl = ALU_AND;
          6'b000100: dec_ctrl = ALU_SUB;
          6'b001010: dec_ctrl = ALU_SLT;
          default:   dec_ill  = 1'b1;
        endcase
      end
      2'b10: begin
        case (funct)
          6'b100001: dec_ctrl = ALU_ADD;
          6'b100011: dec_ctrl = ALU_SUB;
          6'b100100: dec_ctrl = ALU_AND;
          6'b100101: dec_ctrl = ALU_OR;
          6'b100111: dec_ctrl = ALU_NOR;
          6'b101010: dec_ctrl = ALU_SLT;
          6'b011000, 6'b011001,
          6'b011010, 6'b011011: dec_md = 1'b1;
          6'b010000, 6'b010010: dec_ctrl = ALU_ADD;
          default:   dec_ill  = 1'b1;
        endcase
      end
      default: dec_ill = 1'b1;
    endcase
    if (dec_ill) dec_ctrl = ALU_AND;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      alu_control <= '0;
      ctrl_valid  <= 1'b0;
      md_start    <= 1'b0;
      md_op       <= 2'b00;
      md_done     <= 1'b0;
      illegal     <= 1'b0;
    end else begin
      ctrl_valid <= accept;
      md_start   <= 1'b0;
      md_done    <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            alu_control <= CTRL_W'(dec_ctrl);
            illegal     <= dec_ill;
            if (dec_md) begin
              state    <= BUSY;
              md_op    <= funct[1:0];
              md_start <= 1'b1;
              // funct[1] separates div/divu from mult/multu
              cnt      <= funct[1] ? CNT_W'(DIV_LAT) : CNT_W'(MUL_LAT);
            end
          end
        end
        BUSY: begin
          if (cnt == CNT_W'(1)) begin
            state   <= IDLE;
            md_done <= 1'b1;
            cnt     <= '0;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_control_seq.sv
// tb/tb_alu_control_seq.sv - directed plus random checks of alu_control_seq against a timeline model
module tb_alu_control_seq;

  localparam int CW  = 6;
  localparam int MUL = 4;
  localparam int DIV = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          valid_i = 1'b0;
  logic [1:0]    alu_op = 2'b00;
  logic [5:0]    opcode = 6'd0;
  logic [5:0]    funct = 6'd0;
  logic          stall;
  logic [CW-1:0] alu_control;
  logic          ctrl_valid;
  logic          md_start;
  logic [1:0]    md_op;
  logic          md_done;
  logic          illegal;

  alu_control_seq #(.CTRL_W(CW), .MUL_LAT(MUL), .DIV_LAT(DIV), .CNT_W(6)) dut (
    .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .alu_op(alu_op),
    .opcode(opcode), .funct(funct), .stall(stall), .alu_control(alu_control),
    .ctrl_valid(ctrl_valid), .md_start(md_start), .md_op(md_op),
    .md_done(md_done), .illegal(illegal)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  // Model: edge index n; a mult/div accepted at edge s stalls after edges s..s+lat-1
  int         n = 0;
  int         busy_start = -1000;
  int         busy_lat = 0;
  logic [CW-1:0] e_ctrl = '0;
  logic       e_valid = 0, e_ill = 0, e_start = 0, e_done = 0;
  logic [1:0] e_mdop = 2'b00;

  function automatic logic model_stall(int idx);
    return (idx >= busy_start) && (idx < busy_start + busy_lat);
  endfunction

  task automatic decode(input logic [1:0] op, input logic [5:0] opc, input logic [5:0] fn,
                        output int ctrl, output logic ill, output logic md);
    ctrl = 2; ill = 0; md = 0;
    if (op == 2'b01) begin
      if (opc == 6'b001101) ctrl = 1;
      else if (opc == 6'b001100) ctrl = 0;
      else if (opc == 6'b000100) ctrl = 6;
      else if (opc == 6'b001010) ctrl = 7;
      else ill = 1;
    end else if (op == 2'b10) begin
      if (fn == 6'b100001 || fn == 6'b010000 || fn == 6'b010010) ctrl = 2;
      else if (fn == 6'b100011) ctrl = 6;
      else if (fn == 6'b100100) ctrl = 0;
      else if (fn == 6'b100101) ctrl = 1;
      else if (fn == 6'b100111) ctrl = 12;
      else if (fn == 6'b101010) ctrl = 7;
      else if (fn >= 6'd24 && fn <= 6'd27) md = 1;
      else ill = 1;
    end else if (op == 2'b11) ill = 1;
    if (ill) ctrl = 0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".stall"}, 32'(stall), 32'(model_stall(n)));
    chk({tag, ".alu_control"}, 32'(alu_control), 32'(e_ctrl));
    chk({tag, ".ctrl_valid"}, 32'(ctrl_valid), 32'(e_valid));
    chk({tag, ".md_start"}, 32'(md_start), 32'(e_start));
    chk({tag, ".md_op"}, 32'(md_op), 32'(e_mdop));
    chk({tag, ".md_done"}, 32'(md_done), 32'(e_done));
    chk({tag, ".illegal"}, 32'(illegal), 32'(e_ill));
  endtask

  task automatic step(input string tag, input logic v, input logic [1:0] op,
                      input logic [5:0] opc, input logic [5:0] fn);
    int ctrl; logic ill, md, acc;
    valid_i = v; alu_op = op; opcode = opc; funct = fn;
    acc = v && !model_stall(n);
    @(posedge clk); #1;
    n++;
    e_valid = acc;
    if (acc) begin
      decode(op, opc, fn, ctrl, ill, md);
      e_ctrl = CW'(ctrl);
      e_ill  = ill;
      if (md) begin
        busy_start = n;
        busy_lat   = fn[1] ? DIV : MUL;
        e_mdop     = fn[1:0];
      end
    end
    e_start = (n == busy_start);
    e_done  = (n == busy_start + busy_lat);
    check_all(tag);
  endtask

  task automatic model_reset();
    busy_start = -1000; busy_lat = 0;
    e_ctrl = '0; e_valid = 0; e_ill = 0; e_start = 0; e_done = 0; e_mdop = 2'b00;
  endtask

  int lst_opc[6] = '{6'b001101, 6'b001100, 6'b000100, 6'b001010, 6'b000000, 6'b111111};
  int lst_fn[16] = '{6'b100001, 6'b100011, 6'b100100, 6'b100101, 6'b100111, 6'b101010,
                     6'b010000, 6'b010010, 6'b011000, 6'b011001, 6'b011010, 6'b011011,
                     6'b000000, 6'b101011, 6'b100000, 6'b111111};

  initial begin
    // Reset state
    model_reset();
    #2;
    check_all("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    check_all("reset_release");

    // subu decodes to SUB
    step("subu", 1, 2'b10, 6'd0, 6'b100011);
    chk("subu.const", 32'(alu_control), 32'h06);

    // ori then slti then alu_op=11
    step("ori", 1, 2'b01, 6'b001101, 6'd0);
    chk("ori.const", 32'(alu_control), 32'h01);
    step("slti", 1, 2'b01, 6'b001010, 6'd0);
    chk("slti.const", 32'(alu_control), 32'h07);
    step("op11", 1, 2'b11, 6'd0, 6'd0);
    chk("op11.ill", 32'(illegal), 32'h1);
    chk("op11.ctrl", 32'(alu_control), 32'h0);
    step("idle", 0, 2'b00, 6'd0, 6'd0);

    // mult with addu held during stall
    step("mult", 1, 2'b10, 6'd0, 6'b011000);
    chk("mult.start", 32'(md_start), 32'h1);
    for (int i = 0; i < 6; i++) step("mult_hold_addu", 1, 2'b10, 6'd0, 6'b100001);

    // divu then mflo held until accepted on the done cycle
    step("divu", 1, 2'b10, 6'd0, 6'b011011);
    chk("divu.op", 32'(md_op), 32'h3);
    for (int i = 0; i < DIV + 1; i++) step("divu_hold_mflo", 1, 2'b10, 6'd0, 6'b010010);
    chk("mflo.ctrl", 32'(alu_control), 32'h02);

    // back-to-back mult on the done cycle
    step("mult_a", 1, 2'b10, 6'd0, 6'b011001);
    for (int i = 0; i < 2 * MUL + 3; i++) step("mult_b2b", 1, 2'b10, 6'd0, 6'b011000);

    // reset during div busy
    step("idle2", 0, 2'b00, 6'd0, 6'd0);
    step("div", 1, 2'b10, 6'd0, 6'b011010);
    for (int i = 0; i < 9; i++) step("div_busy", 0, 2'b00, 6'd0, 6'd0);
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("rst_busy.stall", 32'(stall), 32'h0);
    check_all("rst_busy");
    @(posedge clk); #1;
    n++;
    check_all("rst_hold");
    rst_n = 1'b1;
    for (int i = 0; i < DIV + 2; i++) step("after_rst", 0, 2'b00, 6'd0, 6'd0);
    step("subu2", 1, 2'b10, 6'd0, 6'b100011);
    chk("subu2.const", 32'(alu_control), 32'h06);

    // random sweep
    for (int i = 0; i < 400; i++) begin
      logic [1:0] op;
      logic [5:0] fn, opc;
      op  = 2'($urandom_range(0, 3));
      opc = 6'(lst_opc[$urandom_range(0, 5)]);
      fn  = 6'(lst_fn[$urandom_range(0, 15)]);
      if (fn[5:2] == 4'b0110 && $urandom_range(0, 3) != 0) fn = 6'b100101;
      step("rand", 1'($urandom_range(0, 3) != 0), op, opc, fn);
      chk("rand.upper", 32'(alu_control[CW-1:4]), 32'h0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
